// File: rtl/inst_sram_slave.sv
// Instruction SRAM slave: 2^DEPTH_LOG2 x 32-bit words behind a byte-addressed SRAM port, plus a burst loader.
// Optional feature: define INST_SRAM_PERF_EN to build the saturating fetch counter on perf_fetch_cnt.
module inst_sram_slave #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h1c000000
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  inst_sram_en,
    input  logic [3:0]            inst_sram_we,
    input  logic [31:0]           inst_sram_addr,
    input  logic [31:0]           inst_sram_wdata,
    output logic [31:0]           inst_sram_rdata,
    input  logic                  ld_start,
    input  logic [DEPTH_LOG2-1:0] ld_base,
    input  logic                  ld_valid,
    input  logic [31:0]           ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  ld_busy,
    output logic                  err_range,
    output logic                  err_align,
    output logic [31:0]           perf_fetch_cnt
);

    localparam int                    DEPTH        = 1 << DEPTH_LOG2;
    localparam logic [32:0]           WINDOW_BYTES = 33'(DEPTH) << 2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE      = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } ld_state_t;

    logic [31:0]           mem [DEPTH];
    logic [31:0]           offset;
    logic                  in_window;
    logic                  misaligned;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  sram_write;

    ld_state_t             state;
    ld_state_t             state_next;
    logic [DEPTH_LOG2-1:0] ptr;
    logic [DEPTH_LOG2-1:0] ptr_next;
    logic                  ld_accept;

    // Offset is taken unsigned, so addresses below BASE_ADDR wrap high and fall outside the window.
    assign offset     = inst_sram_addr - BASE_ADDR;
    assign in_window  = ({1'b0, offset} < WINDOW_BYTES);
    assign misaligned = |inst_sram_addr[1:0];
    assign word_idx   = offset[DEPTH_LOG2+1:2];
    assign sram_write = inst_sram_en && in_window && (|inst_sram_we);

    // Loader handshake: a beat transfers on a rising edge where ld_valid && ld_ready.
    // ld_ready is only offered in LOAD and is withdrawn whenever the SRAM port is active.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        ld_ready   = 1'b0;
        ld_busy    = 1'b0;
        ld_accept  = 1'b0;
        case (state)
            IDLE: begin
                if (ld_start) begin
                    state_next = LOAD;
                    ptr_next   = ld_base;
                end
            end
            LOAD: begin
                ld_busy   = 1'b1;
                ld_ready  = !inst_sram_en;
                ld_accept = ld_valid && !inst_sram_en;
                if (ld_accept) begin
                    ptr_next = ptr + PTR_ONE;
                    if (ld_last) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Memory has no reset; the SRAM port and the loader never write in the same cycle.
    always_ff @(posedge clk) begin
        if (sram_write) begin
            for (int i = 0; i < 4; i++) begin
                if (inst_sram_we[i]) begin
                    mem[word_idx][8*i +: 8] <= inst_sram_wdata[8*i +: 8];
                end
            end
        end else if (ld_accept) begin
            mem[ptr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_sram_rdata <= 32'h0;
        end else if (inst_sram_en) begin
            inst_sram_rdata <= in_window ? mem[word_idx] : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_range <= 1'b0;
            err_align <= 1'b0;
        end else if (inst_sram_en) begin
            if (!in_window) begin
                err_range <= 1'b1;
            end
            if (misaligned) begin
                err_align <= 1'b1;
            end
        end
    end

`ifdef INST_SRAM_PERF_EN
    logic [31:0] fetch_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_cnt <= 32'h0;
        end else if (inst_sram_en && (inst_sram_we == 4'h0) && (fetch_cnt != 32'hffffffff)) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt;
`else
    assign perf_fetch_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_inst_sram_slave.sv
// Directed bench for inst_sram_slave: vector table for SRAM port accesses plus loader/reset sequences.
module tb_inst_sram_slave;

    logic        clk;
    logic        resetn;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        ld_start;
    logic [9:0]  ld_base;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        ld_busy;
    logic        err_range;
    logic        err_align;
    logic [31:0] perf_fetch_cnt;

    int          num_vectors = 0;
    int          num_fail    = 0;
    logic [31:0] exp_fetch   = 32'h0;

    typedef struct {
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_range;
        logic        exp_align;
    } vec_t;

    vec_t vecs [17];

    inst_sram_slave #(
        .DEPTH_LOG2(10),
        .BASE_ADDR (32'h1c000000)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_we   (inst_sram_we),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .ld_start       (ld_start),
        .ld_base        (ld_base),
        .ld_valid       (ld_valid),
        .ld_data        (ld_data),
        .ld_last        (ld_last),
        .ld_ready       (ld_ready),
        .ld_busy        (ld_busy),
        .err_range      (err_range),
        .err_align      (err_align),
        .perf_fetch_cnt (perf_fetch_cnt)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_perf();
`ifdef INST_SRAM_PERF_EN
        return exp_fetch;
`else
        return 32'h0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_vectors++;
        if (act !== exp) begin
            num_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after it, and inputs change there too.
    task automatic step();
        if (resetn && inst_sram_en && (inst_sram_we == 4'h0)) begin
            exp_fetch = exp_fetch + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sram_idle();
        inst_sram_en    = 1'b0;
        inst_sram_we    = 4'h0;
        inst_sram_addr  = 32'h0;
        inst_sram_wdata = 32'h0;
    endtask

    task automatic sram_read(input logic [31:0] addr);
        inst_sram_en    = 1'b1;
        inst_sram_we    = 4'h0;
        inst_sram_addr  = addr;
        inst_sram_wdata = 32'h0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " rdata"},     inst_sram_rdata,     32'h0);
        check({tag, " ld_busy"},   32'(ld_busy),        32'h0);
        check({tag, " ld_ready"},  32'(ld_ready),       32'h0);
        check({tag, " err_range"}, 32'(err_range),      32'h0);
        check({tag, " err_align"}, 32'(err_align),      32'h0);
        check({tag, " perf"},      perf_fetch_cnt,      32'h0);
    endtask

    initial begin
        resetn   = 1'b0;
        ld_start = 1'b0;
        ld_base  = 10'd0;
        ld_valid = 1'b0;
        ld_data  = 32'h0;
        ld_last  = 1'b0;
        sram_idle();

        // Reset state
        #3;
        check_reset_values("reset");
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        step();

        // Burst load 0x11, 0x22, 0x33 at base 0
        ld_base  = 10'd0;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        check("load busy entry", 32'(ld_busy), 32'h1);
        check("load ready entry", 32'(ld_ready), 32'h1);
        ld_valid = 1'b1;
        ld_data  = 32'h11;
        step();
        check("load busy beat1", 32'(ld_busy), 32'h1);
        ld_data = 32'h22;
        step();
        check("load busy beat2", 32'(ld_busy), 32'h1);
        ld_data = 32'h33;
        ld_last = 1'b1;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("load busy done", 32'(ld_busy), 32'h0);
        check("load ready idle", 32'(ld_ready), 32'h0);

        sram_read(32'h1c000004);
        step();
        check("read word1", inst_sram_rdata, 32'h22);

        // SRAM port vectors
        vecs[0]  = '{1'b1, 4'h0, 32'h1c000000, 32'h0,        32'h00000011, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'h0, 32'h1c000008, 32'h0,        32'h00000033, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 4'h3, 32'h1c000000, 32'hAABBCCDD, 32'h00000011, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 4'h0, 32'h1c000000, 32'h0,        32'h0000CCDD, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 4'hC, 32'h1c000000, 32'h12345678, 32'h0000CCDD, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 4'h0, 32'h1c000000, 32'h0,        32'h1234CCDD, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 4'hF, 32'h1c000004, 32'hDEADBEEF, 32'h00000022, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 4'h0, 32'h1c000004, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4'hF, 32'h1c000008, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 4'h0, 32'h1bfffffc, 32'h0,        32'h00000000, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 4'h0, 32'h1c000004, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 4'h0, 32'h1c001000, 32'h0,        32'h00000000, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 4'hF, 32'h1c001000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 4'h0, 32'h1c000000, 32'h0,        32'h1234CCDD, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 4'h1, 32'h1c000009, 32'h000000AA, 32'h00000033, 1'b1, 1'b1};
        vecs[15] = '{1'b1, 4'h0, 32'h1c000008, 32'h0,        32'h000000AA, 1'b1, 1'b1};
        vecs[16] = '{1'b1, 4'h0, 32'h1c000006, 32'h0,        32'hDEADBEEF, 1'b1, 1'b1};

        for (int i = 0; i < 17; i++) begin
            inst_sram_en    = vecs[i].en;
            inst_sram_we    = vecs[i].we;
            inst_sram_addr  = vecs[i].addr;
            inst_sram_wdata = vecs[i].wdata;
            step();
            check($sformatf("vec%0d rdata", i), inst_sram_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d err_range", i), 32'(err_range), 32'(vecs[i].exp_range));
            check($sformatf("vec%0d err_align", i), 32'(err_align), 32'(vecs[i].exp_align));
            check($sformatf("vec%0d perf", i), perf_fetch_cnt, exp_perf());
        end
        sram_idle();

        // Loader stall under SRAM priority, then wrap from word 1023 to word 0
        ld_base  = 10'd1023;
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 32'hA5A50001;
        #1;
        check("idle ready with valid", 32'(ld_ready), 32'h0);
        step();
        ld_base = 10'd5;
        sram_read(32'h1c000000);
        #1;
        check("stall ready c1", 32'(ld_ready), 32'h0);
        step();
        check("stall ready c2", 32'(ld_ready), 32'h0);
        check("stall busy", 32'(ld_busy), 32'h1);
        step();
        ld_start = 1'b0;
        sram_idle();
        #1;
        check("stall released ready", 32'(ld_ready), 32'h1);
        step();
        ld_data = 32'hA5A50002;
        ld_last = 1'b1;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("wrap busy done", 32'(ld_busy), 32'h0);
        sram_read(32'h1c000ffc);
        step();
        check("wrap word1023", inst_sram_rdata, 32'hA5A50001);
        sram_read(32'h1c000000);
        step();
        check("wrap word0", inst_sram_rdata, 32'hA5A50002);
        check("perf after wrap", perf_fetch_cnt, exp_perf());
        sram_idle();

        // Reset asserted mid-burst
        ld_base  = 10'd2;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        ld_valid = 1'b1;
        ld_data  = 32'h00000077;
        step();
        ld_data = 32'h00000088;
        #2;
        resetn = 1'b0;
        exp_fetch = 32'h0;
        #1;
        check_reset_values("midburst reset");
        ld_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        step();
        check("post reset busy", 32'(ld_busy), 32'h0);
        sram_read(32'h1c000008);
        step();
        check("retained word2", inst_sram_rdata, 32'h00000077);
        check("post reset err_range", 32'(err_range), 32'h0);
        check("post reset perf", perf_fetch_cnt, exp_perf());
        sram_idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_fail);
        $finish;
    end

endmodule

// File: doc/inst_sram_slave.md
INST_SRAM_SLAVE -- requirements
Module: inst_sram_slave

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, word-count exponent (memory = 2^DEPTH_LOG2 x 32-bit words).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h1c000000, byte address of word 0.
REQ-003 SHALL have one clock and asynchronous active-low reset: clk  in  1  clock, all state updates on rising edge.
REQ-004 resetn  in  1  asynchronous active-low reset.
REQ-005 inst_sram_en  in  1  access request this cycle.
REQ-006 inst_sram_we  in  4  byte write enables, bit i = wdata[8i+7:8i].
REQ-007 inst_sram_addr  in  32  byte address.
REQ-008 inst_sram_wdata  in  32  write data.
REQ-009 inst_sram_rdata  out  32  read data, registered.
REQ-010 ld_start  in  1  begin burst load at ld_base.
REQ-011 ld_base  in  DEPTH_LOG2  first word index of burst.
REQ-012 ld_valid  in  1  ld_data beat valid.
REQ-013 ld_data  in  32  load word.
REQ-014 ld_last  in  1  final beat of burst.
REQ-015 ld_ready  out  1  beat accepted when ld_valid && ld_ready.
REQ-016 ld_busy  out  1  loader FSM in LOAD.
REQ-017 err_range  out  1  sticky: access outside window.
REQ-018 err_align  out  1  sticky: access with addr[1:0] != 0.
REQ-019 perf_fetch_cnt  out  32  fetch counter (see Configuration).

Function
REQ-020 Word index SHALL be (inst_sram_addr - BASE_ADDR) >> 2; in-window iff 0 <= offset < 4*2^DEPTH_LOG2 (unsigned compare, no wrap).
REQ-021 On edge with inst_sram_en=1, in-window: inst_sram_rdata SHALL load old mem[index] (read-before-write), latency exactly 1 cycle.
REQ-022 Same edge: each byte with inst_sram_we[i]=1 SHALL be written; we=4'h0 is pure read.
REQ-023 inst_sram_en=1, out-of-window: rdata SHALL load 32'h0, no write, err_range set.
REQ-024 inst_sram_en=1 with addr[1:0]!=0: err_align set; access proceeds using addr[1:0] ignored.
REQ-025 inst_sram_en=0: rdata SHALL hold its previous value.
REQ-026 Loader FSM SHALL have states IDLE and LOAD; ld_busy=1 only in LOAD.
REQ-027 IDLE -> LOAD on ld_start=1; load pointer <= ld_base; ld_start in LOAD ignored.
REQ-028 In LOAD, ld_ready SHALL equal !inst_sram_en (SRAM port has priority, loader stalls).
REQ-029 Accepted beat SHALL write full word mem[ptr] and increment ptr modulo 2^DEPTH_LOG2 (wrap to 0).
REQ-030 Accepted beat with ld_last=1 SHALL return FSM to IDLE the next cycle; ld_ready=0 in IDLE.
REQ-031 Same-cycle loader write and SRAM access to one word cannot occur (REQ-028).

Reset
REQ-032 resetn=0 SHALL asynchronously force: rdata=0, FSM=IDLE, ptr=0, ld_ready=0, ld_busy=0, err_range=0, err_align=0, perf_fetch_cnt=0.
REQ-033 Memory contents SHALL NOT be reset; reset mid-burst aborts the burst, already-written words retained.
REQ-034 Sticky error flags SHALL clear only on reset.

Configuration
REQ-035 Macro INST_SRAM_PERF_EN defined: perf_fetch_cnt SHALL increment by 1 on each edge with inst_sram_en=1 and we=4'h0, saturating at 32'hffffffff.
REQ-036 Macro undefined: no counter logic; perf_fetch_cnt SHALL be constant 0.

Verification
REQ-037 Reset release, load burst base 0 data 0x11,0x22,0x33 (last on 3rd) -> ld_busy 1 for 3 beats then 0; read 0x1c000004 -> rdata 0x22 next cycle.
REQ-038 Write we=4'b0011 wdata 0xAABBCCDD to 0x1c000000 over 0x00000011 -> subsequent read returns 0x0000CCDD; write cycle itself returns 0x00000011.
REQ-039 Read 0x1bfffffc and 0x1c001000 (DEPTH_LOG2=10) -> rdata 0, err_range=1, memory unchanged.
REQ-040 LOAD with ld_valid=1 and inst_sram_en=1 for 2 cycles -> ld_ready=0, ptr unchanged; beats accepted after en drops; base 1023 two beats -> words 1023 and 0 written.
REQ-041 With INST_SRAM_PERF_EN: 5 reads + 2 writes -> perf_fetch_cnt=5; without macro -> 0; assert resetn mid-burst -> all outputs to REQ-032 values immediately.
